// File: rtl/oneshot_timer_arbiter.sv
// oneshot_timer_arbiter: round-robin arbiter sharing one one-shot timer among NREQ requesters
module oneshot_timer_arbiter #(
  parameter int NREQ      = 4,
  parameter int CNT_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CNT_WIDTH-1:0] dur,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      count
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, last, last_n, win;
  logic [CNT_WIDTH-1:0] dur_l, dur_n, count_n, win_dur;
  // round-robin pick: scan far-to-near from last+1 so the nearest requester wins
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(last) + 1 + k) % NREQ]) win = IW'((int'(last) + 1 + k) % NREQ);
  end
  assign win_dur = dur[int'(win)*CNT_WIDTH +: CNT_WIDTH];
  // state register; reset parks the pointer so requester 0 wins first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      dur_l <= '0;
      count <= '0;
      last  <= IW'(NREQ - 1);
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dur_l <= dur_n;
      count <= count_n;
      last  <= last_n;
    end
  // next state: grant in IDLE, count/abort/complete in RUN, single-cycle DONE
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dur_n   = dur_l;
    count_n = count;
    last_n  = last;
    case (state)
      IDLE: if (|req) begin
        state_n = RUN;
        idx_n   = win;
        last_n  = win;
        dur_n   = (win_dur == '0) ? CNT_WIDTH'(1) : win_dur;
        count_n = '0;
      end
      RUN: if (!req[idx]) begin
        state_n = IDLE;
        count_n = '0;
      end else if (count == dur_l - CNT_WIDTH'(1)) begin
        state_n = DONE;
        count_n = '0;
      end else count_n = count + CNT_WIDTH'(1);
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign grant = (state == RUN)  ? NREQ'(1) << idx : '0;
  assign done  = (state == DONE) ? NREQ'(1) << idx : '0;
  assign busy  = state != IDLE;
endmodule

// File: tb/tb_oneshot_timer_arbiter.sv
// tb_oneshot_timer_arbiter: directed scenarios checked against a cycle model of the arbiter rules
module tb_oneshot_timer_arbiter;
  localparam int N = 4;
  localparam int W = 12;
  logic clk = 0;
  logic rst = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] dur = '0;
  logic [N-1:0] grant, done;
  logic busy;
  logic [W-1:0] count;
  int tests = 0;
  int fails = 0;
  int m_owner = -1;
  int m_done_who = -1;
  int m_elapsed = 0;
  int m_len = 0;
  int m_last = N - 1;
  int gq[$];
  int glen[$];
  int dq[$];
  int cur_len = 0;
  logic [N-1:0] pg = '0;

  oneshot_timer_arbiter #(.NREQ(N), .CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .dur(dur),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // model: one owner at a time, holds for its duration, then a one-cycle done, then one idle cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_done_who = -1; m_elapsed = 0; m_len = 0; m_last = N - 1;
    end else if (m_done_who >= 0) begin
      m_done_who = -1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) m_owner = -1;
      else if (m_elapsed + 1 >= m_len) begin m_done_who = m_owner; m_owner = -1; end
      else m_elapsed++;
    end else if (req != 0) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
      m_last = m_owner;
      m_len = dur[m_owner*W +: W] == 0 ? 1 : int'(dur[m_owner*W +: W]);
      m_elapsed = 0;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("grant", 32'(grant), m_owner >= 0 ? 32'(1) << m_owner : 32'd0);
    chk("done", 32'(done), m_done_who >= 0 ? 32'(1) << m_done_who : 32'd0);
    chk("busy", 32'(busy), 32'(m_owner >= 0 || m_done_who >= 0));
    chk("count", 32'(count), m_owner >= 0 ? 32'(m_elapsed) : 32'd0);
  end

  // burst log: who was granted, for how long, and who got done
  always @(negedge clk) begin
    if (rst) begin
      cur_len = 0;
      pg = '0;
    end else begin
      if (grant != 0 && pg == 0) begin gq.push_back(oh(grant)); cur_len = 1; end
      else if (grant != 0) cur_len++;
      if (grant == 0 && pg != 0) glen.push_back(cur_len);
      if (done != 0) dq.push_back(oh(done));
      pg = grant;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int i, input int v);
    dur[i*W +: W] = W'(v);
  endtask

  task automatic clr();
    gq.delete(); glen.delete(); dq.delete();
  endtask

  task automatic wait_done(input int who);
    int n = 0;
    while (!done[who] && n < 200) begin @(negedge clk); n++; end
    chk("wait_done", 32'(done[who]), 32'd1);
  endtask

  task automatic qchk(input string name, input int q[$], input int i, input int exp);
    chk(name, i < q.size() ? q[i] : -1, exp);
  endtask

  task automatic do_reset();
    #1 rst = 1;
    tick(2);
    rst = 0;
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_grant", 32'(grant), 32'd0);
    // single requester, duration 5
    clr();
    set_dur(1, 5); req = 4'b0010;
    wait_done(1);
    req = '0;
    tick(3);
    qchk("single_owner", gq, 0, 1);
    qchk("single_len", glen, 0, 5);
    qchk("single_done", dq, 0, 1);
    chk("single_ndone", dq.size(), 1);
    chk("single_busy", 32'(busy), 32'd0);
    // round robin from a fresh reset
    do_reset();
    clr();
    for (int i = 0; i < N; i++) set_dur(i, 2);
    req = 4'b1111;
    tick(20);
    req = '0;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      qchk("rr_order", gq, i, rr_exp[i]);
      qchk("rr_len", glen, i, 2);
    end
    // abort of requester 2, next search starts at 3
    clr();
    set_dur(2, 10); set_dur(3, 1); req = 4'b0100;
    tick(1);
    tick(2);
    req = 4'b1011;
    wait_done(3);
    req = '0;
    tick(3);
    qchk("abort_first", gq, 0, 2);
    qchk("abort_len", glen, 0, 3);
    qchk("abort_next", gq, 1, 3);
    chk("abort_ndone", dq.size(), 1);
    qchk("abort_done_who", dq, 0, 3);
    // zero duration acts as one
    clr();
    set_dur(0, 0); req = 4'b0001;
    wait_done(0);
    req = '0;
    tick(3);
    qchk("zero_owner", gq, 0, 0);
    qchk("zero_len", glen, 0, 1);
    qchk("zero_done", dq, 0, 0);
    // duration latched at grant
    clr();
    set_dur(3, 4); req = 4'b1000;
    tick(1);
    set_dur(3, 9);
    wait_done(3);
    req = '0;
    tick(3);
    qchk("latch_owner", gq, 0, 3);
    qchk("latch_len", glen, 0, 4);
    // reset in the middle of a run
    clr();
    set_dur(1, 20); req = 4'b0010;
    tick(1);
    tick(6);
    chk("midrun_count", 32'(count), 32'd6);
    rst = 1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick(2);
    chk("rst_nodone", dq.size(), 0);
    clr();
    set_dur(1, 3); set_dur(3, 3); req = 4'b1010;
    rst = 0;
    wait_done(1);
    req = '0;
    tick(3);
    qchk("rst_first", gq, 0, 1);
    qchk("rst_len", glen, 0, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
